// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter for the memory-dump path.
// Bytes arrive on a valid/ack handshake, wait in a small circular FIFO and
// are serialised LSB first on a registered tx pin. Back-to-back frames are
// contiguous: the stop bit of one frame is followed directly by the next
// start bit when the FIFO still holds data.
module uart_tx_buffered #(
    parameter int DIV     = 104,   // clock cycles per UART bit, 2..65535
    parameter int FIFO_AW = 2      // FIFO depth = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ack,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               ack_q;

    // Serialiser state
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       sh_q,    sh_d;
    logic             tx_q,    tx_d;

    logic push;
    logic pop;
    logic div_end;
    logic fifo_nonempty;

    // The registered ack blocks a second capture of the same byte while the
    // producer is still holding in_valid through the ack cycle.
    assign push          = in_valid & ~ack_q & (count_q != LVL_FULL);
    assign div_end       = (div_q == DIV_LAST);
    assign fifo_nonempty = (count_q != '0);

    // Frame sequencing: start bit, 8 data bits LSB first, stop bit; pops the
    // FIFO head whenever a new frame begins.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    div_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (div_end) begin
                    div_d   = '0;
                    tx_d    = sh_q[0];
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // Shift so the next bit to send is always sh[1] here.
                        tx_d  = sh_q[1];
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (div_end) begin
                    div_d = '0;
                    if (fifo_nonempty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        sh_d    = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                div_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serialiser registers; reset forces the line idle and aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // FIFO payload storage; contents are only read when the level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the ack strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= push;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_ONE;
                2'b01:   count_q <= count_q - LVL_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign in_ack     = ack_q;
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) | fifo_nonempty;
    assign fifo_level = count_q;

endmodule
